// File: rtl/instr_fetch_unit.sv
// Fetch stage: turns accepted PCs into in-order imem reads and buffers {instr, pc} for decode.
// Latency: instr visible 2 cycles after PC accept plus memory latency; no response bypass.
// Backpressure: credit of DEPTH entries in flight; imem request held until ready; flush drops in-flight.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     drop_cnt;
    logic [CW:0]       in_flight;
    logic [PW-1:0]     pq_wr, pq_rd;
    logic [PW-1:0]     buf_wr, buf_rd;
    logic [ADDR_W-1:0] pq_mem  [DEPTH];
    logic [DATA_W-1:0] buf_dat [DEPTH];
    logic [ADDR_W-1:0] buf_pc  [DEPTH];
    logic              pc_acc, req_hs, rsp_drop, rsp_keep, deq;
    logic              unused_pc_lsbs;

    assign unused_pc_lsbs = ^pc_in[1:0];

    assign in_flight = {{CW{1'b0}}, imem_req_valid} + {1'b0, outstanding} + {1'b0, buf_count};
    assign pc_ready  = !flush && !imem_req_valid && (in_flight < (CW+1)'(DEPTH));
    assign pc_acc    = pc_valid && pc_ready;
    assign req_hs    = imem_req_valid && imem_req_ready;
    // Responses to requests issued before a redirect are discarded, including one landing in the flush cycle.
    assign rsp_drop  = imem_rsp_valid && (flush || drop_cnt != '0);
    assign rsp_keep  = imem_rsp_valid && !rsp_drop;
    assign deq       = instr_valid && instr_ready;

    assign instr_valid = (buf_count != '0);
    assign instr       = buf_dat[buf_rd];
    assign instr_pc    = buf_pc[buf_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_valid <= 1'b0;
            imem_addr      <= '0;
        end else if (flush) begin
            imem_req_valid <= 1'b0;
        end else if (pc_acc) begin
            imem_req_valid <= 1'b1;
            imem_addr      <= {pc_in[ADDR_W-1:2], 2'b00};
        end else if (req_hs) begin
            imem_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_hs) - CW'(imem_rsp_valid);
            if (flush)
                drop_cnt <= outstanding + CW'(req_hs) - CW'(imem_rsp_valid);
            else if (rsp_drop)
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq_wr <= '0;
            pq_rd <= '0;
        end else if (flush) begin
            pq_wr <= '0;
            pq_rd <= '0;
        end else begin
            if (pc_acc)
                pq_wr <= pq_wr + PW'(1);
            if (rsp_keep)
                pq_rd <= pq_rd + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pc_acc)
            pq_mem[pq_wr] <= pc_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else if (flush) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
        end else begin
            if (rsp_keep)
                buf_wr <= buf_wr + PW'(1);
            if (deq)
                buf_rd <= buf_rd + PW'(1);
            buf_count <= buf_count + CW'(rsp_keep) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_dat[i] <= '0;
                buf_pc[i]  <= '0;
            end
        end else if (rsp_keep) begin
            buf_dat[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]  <= pq_mem[pq_rd];
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with epochs, expected-instruction queue,
// directed scenarios plus randomized traffic.
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; int ep; int rdy;} mreq_t;
    typedef struct packed {logic [31:0] d; logic [31:0] pc;} ent_t;

    mreq_t       memq[$];
    ent_t        expq[$];
    ent_t        deliv_q[$];
    logic [31:0] rsp_data_q[$];
    int          epoch = 0;
    int          cyc = 0;
    int          lat_max = 0;
    bit          mem_hold = 0;
    bit          pend = 0;
    logic [31:0] pend_pc = '0;
    int          checks = 0;
    int          errors = 0;

    // One clock cycle: present memory response, compare against the model, advance the model.
    task automatic step(output bit acc_o);
        mreq_t r;
        bit    rsp, deq_m, hs_m, acc_m, fl, exp_rdy;
        int    inflight;
        if (!mem_hold && memq.size() != 0 && memq[0].rdy <= cyc) begin
            imem_rsp_valid = 1'b1;
            if (rsp_data_q.size() != 0) imem_rsp_data = rsp_data_q.pop_front();
            else imem_rsp_data = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        inflight = int'(pend) + memq.size() + expq.size();
        exp_rdy  = !flush && !pend && (inflight < DEPTH);
        checks++;
        if (instr_valid !== (expq.size() != 0)) begin
            errors++;
            $display("FAIL instr_valid cyc=%0d got=%b want=%b", cyc, instr_valid, expq.size() != 0);
        end
        if (expq.size() != 0) begin
            checks++;
            if (instr !== expq[0].d || instr_pc !== expq[0].pc) begin
                errors++;
                $display("FAIL instr_head cyc=%0d got=%h/%h want=%h/%h", cyc, instr, instr_pc, expq[0].d, expq[0].pc);
            end
        end
        checks++;
        if (imem_req_valid !== pend) begin
            errors++;
            $display("FAIL imem_req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, pend);
        end
        if (pend) begin
            checks++;
            if (imem_addr !== {pend_pc[31:2], 2'b00}) begin
                errors++;
                $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, {pend_pc[31:2], 2'b00});
            end
        end
        checks++;
        if (pc_ready !== exp_rdy) begin
            errors++;
            $display("FAIL pc_ready cyc=%0d got=%b want=%b", cyc, pc_ready, exp_rdy);
        end
        rsp   = imem_rsp_valid;
        fl    = flush;
        deq_m = instr_ready && (expq.size() != 0);
        hs_m  = pend && imem_req_ready;
        acc_m = pc_valid && exp_rdy;
        if (instr_valid && instr_ready && !fl) deliv_q.push_back('{instr, instr_pc});
        @(posedge clk);
        if (deq_m) void'(expq.pop_front());
        if (rsp) begin
            r = memq.pop_front();
            if (!fl && r.ep == epoch) expq.push_back('{imem_rsp_data, r.pc});
        end
        if (hs_m) begin
            memq.push_back('{pend_pc, epoch, cyc + 1 + int'($urandom_range(0, lat_max))});
            pend = 0;
        end
        if (acc_m) begin
            pend    = 1;
            pend_pc = pc_in;
        end
        if (fl) begin
            expq.delete();
            epoch++;
            pend = 0;
        end
        cyc++;
        acc_o = acc_m;
        @(negedge clk);
    endtask

    task automatic drain();
        bit a;
        bit done = 0;
        pc_valid = 0; flush = 0; instr_ready = 1; mem_hold = 0; imem_req_ready = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            step(a);
            done = !pend && memq.size() == 0 && expq.size() == 0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout pend=%0d memq=%0d expq=%0d", pend, memq.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b addr=%h iv=%b instr=%h ipc=%h want all 0",
                     imem_req_valid, imem_addr, instr_valid, instr, instr_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit a;
        int n = 0;
        lat_max = 0; imem_req_ready = 1; instr_ready = 0;
        rsp_data_q.push_back(32'h00500093);
        pc_valid = 1; pc_in = 32'h0;
        step(a);
        pc_valid = 0;
        checks++;
        if (!a) begin errors++; $display("FAIL basic_accept got=0 want=1"); end
        while (!instr_valid && n < 10) begin step(a); n++; end
        checks++;
        if (n != 2 || instr !== 32'h00500093 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL basic_fetch wait=%0d instr=%h pc=%h want wait=2 instr=00500093 pc=0", n, instr, instr_pc);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bit a;
        int n = 0;
        lat_max = 0; imem_req_ready = 1; instr_ready = 0;
        pc_valid = 1; pc_in = 32'h0;
        for (int i = 0; i < 12; i++) begin
            step(a);
            if (a) begin n++; pc_in = pc_in + 32'h4; end
        end
        checks++;
        if (n != 2 || pc_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_credit accepts=%0d pc_ready=%b want 2/0", n, pc_ready);
        end
        instr_ready = 1;
        step(a);
        instr_ready = 0;
        for (int i = 0; i < 4 && n < 3; i++) begin
            step(a);
            if (a) n++;
        end
        pc_valid = 0;
        checks++;
        if (n != 3) begin errors++; $display("FAIL b2b_third accepts=%0d want 3", n); end
        drain();
    endtask

    task automatic test_req_stall();
        bit a;
        int nhs = 0;
        lat_max = 0; imem_req_ready = 0; instr_ready = 1;
        pc_valid = 1; pc_in = 32'h43;
        step(a);
        pc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
                errors++;
                $display("FAIL stall_hold i=%0d got=%b/%h want=1/00000040", i, imem_req_valid, imem_addr);
            end
            step(a);
        end
        imem_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (imem_req_valid && imem_req_ready) nhs++;
            step(a);
        end
        checks++;
        if (nhs != 1) begin errors++; $display("FAIL stall_dup handshakes=%0d want 1", nhs); end
        drain();
    endtask

    task automatic test_flush();
        bit a;
        int n = 0;
        lat_max = 0; imem_req_ready = 1; instr_ready = 1; mem_hold = 1;
        pc_valid = 1; pc_in = 32'h200;
        for (int i = 0; i < 12; i++) begin
            step(a);
            if (a) begin n++; pc_in = pc_in + 32'h4; if (n == 2) pc_valid = 0; end
            if (n == 2 && !imem_req_valid) break;
        end
        checks++;
        if (n != 2 || memq.size() != 2) begin
            errors++;
            $display("FAIL flush_setup accepts=%0d outstanding=%0d want 2/2", n, memq.size());
        end
        deliv_q.delete();
        rsp_data_q.push_back(32'hAAAA);
        rsp_data_q.push_back(32'hBBBB);
        rsp_data_q.push_back(32'hCCCC);
        flush = 1;
        step(a);
        flush = 0; mem_hold = 0;
        pc_valid = 1; pc_in = 32'h100;
        for (int i = 0; i < 20; i++) begin
            step(a);
            if (a) pc_valid = 0;
        end
        pc_valid = 0;
        checks++;
        if (deliv_q.size() != 1) begin
            errors++;
            $display("FAIL flush_count delivered=%0d want 1", deliv_q.size());
        end else if (deliv_q[0].d !== 32'hCCCC || deliv_q[0].pc !== 32'h100) begin
            errors++;
            $display("FAIL flush_data got=%h/%h want 0000cccc/00000100", deliv_q[0].d, deliv_q[0].pc);
        end
        drain();
    endtask

    task automatic test_enq_deq_same_cycle();
        bit a;
        int n = 0;
        lat_max = 0; imem_req_ready = 1; instr_ready = 0; mem_hold = 1;
        rsp_data_q.push_back(32'h1111);
        rsp_data_q.push_back(32'h2222);
        pc_valid = 1; pc_in = 32'h300;
        for (int i = 0; i < 12; i++) begin
            step(a);
            if (a) begin n++; pc_in = pc_in + 32'h4; if (n == 2) pc_valid = 0; end
            if (n == 2 && !imem_req_valid) break;
        end
        mem_hold = 0;
        step(a);
        deliv_q.delete();
        instr_ready = 1;
        step(a);
        instr_ready = 0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h2222 || instr_pc !== 32'h304 ||
            deliv_q.size() != 1) begin
            errors++;
            $display("FAIL same_cycle iv=%b instr=%h pc=%h deq=%0d want 1/2222/304/1",
                     instr_valid, instr, instr_pc, deliv_q.size());
        end else begin
            checks++;
            if (deliv_q[0].d !== 32'h1111 || deliv_q[0].pc !== 32'h300) begin
                errors++;
                $display("FAIL same_cycle_order got=%h/%h want 1111/300", deliv_q[0].d, deliv_q[0].pc);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit a;
        int n = 0;
        lat_max = 0; imem_req_ready = 1; instr_ready = 0;
        pc_valid = 1; pc_in = 32'h500;
        for (int i = 0; i < 12; i++) begin
            step(a);
            if (a) begin n++; pc_in = pc_in + 32'h4; if (n == 2) begin pc_valid = 0; mem_hold = 1; end end
            if (n == 2 && !imem_req_valid) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got req=%b addr=%h iv=%b instr=%h ipc=%h want all 0",
                     imem_req_valid, imem_addr, instr_valid, instr, instr_pc);
        end
        memq.delete(); expq.delete(); rsp_data_q.delete();
        pend = 0; mem_hold = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_random();
        bit a;
        lat_max = 3; mem_hold = 0;
        for (int i = 0; i < 800; i++) begin
            pc_valid       = ($urandom_range(0, 1) == 1);
            pc_in          = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            imem_req_ready = ($urandom_range(0, 9) < 7);
            instr_ready    = ($urandom_range(0, 9) < 6);
            flush          = ($urandom_range(0, 19) == 0);
            step(a);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_req_stall();
        test_flush();
        test_enq_deq_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
